// File: rtl/alu_muldiv_if.sv
// -----------------------------------------------------------------------------
// alu_muldiv_if
// Bus between a requester (register-file side) and the multi-cycle
// multiply/divide unit.
//   start, op, a, b    : request side (requester -> unit)
//   busy, done         : status (unit -> requester)
//   result_hi/lo       : product upper/lower half, or remainder/quotient
//   div0, zero         : flags describing the last completed operation
// -----------------------------------------------------------------------------
interface alu_muldiv_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div0;
    logic             zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result_hi, result_lo, div0, zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_hi, result_lo, div0, zero
    );
endinterface

// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
// Iterative unsigned multiply / divide unit, one iteration per clock.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset, aborts any running operation
//   bus  : alu_muldiv_if slave port
//          op = 0 : {result_hi, result_lo} = a * b (shift-add, LSB-first on b)
//          op = 1 : result_lo = a / b, result_hi = a % b (restoring division)
//          a divide by zero finishes after one cycle with div0 = 1,
//          result_lo = all ones and result_hi = a.
// Results and flags are registered and only change when the FIN state is
// entered, so partial values never appear on the bus.
// -----------------------------------------------------------------------------
module alu_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    alu_muldiv_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;

    logic [CW-1:0]    cnt_r;
    logic             op_r;
    logic             div0_pend_r;
    // Working registers shared by both operations:
    //   multiply : {acc_hi_r, acc_lo_r} is the product/multiplier pair,
    //              opnd_r is the multiplicand (a)
    //   divide   : acc_hi_r is the partial remainder, acc_lo_r shifts the
    //              dividend out and the quotient in, opnd_r is the divisor (b)
    logic [WIDTH-1:0] acc_hi_r;
    logic [WIDTH-1:0] acc_lo_r;
    logic [WIDTH-1:0] opnd_r;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_hi_r;
    logic [WIDTH-1:0] result_lo_r;
    logic             div0_r;
    logic             zero_r;

    logic             last_iter_s;
    logic             req_div0_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shift_rem_s;
    logic [WIDTH-1:0] nxt_hi_s;
    logic [WIDTH-1:0] nxt_lo_s;
    logic             nxt_zero_s;

    assign req_div0_s  = bus.op && (bus.b == {WIDTH{1'b0}});
    assign last_iter_s = div0_pend_r || (cnt_r == CW'(WIDTH - 1));

    // One multiply or divide iteration computed from the working registers.
    always_comb begin
        sum_s       = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        shift_rem_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
        nxt_hi_s    = {WIDTH{1'b0}};
        nxt_lo_s    = {WIDTH{1'b0}};
        if (op_r) begin
            // Restoring step: the difference always fits WIDTH bits when
            // the subtraction succeeds, since the remainder stays below b.
            if (shift_rem_s >= {1'b0, opnd_r}) begin
                nxt_hi_s = shift_rem_s[WIDTH-1:0] - opnd_r;
                nxt_lo_s = {acc_lo_r[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi_s = shift_rem_s[WIDTH-1:0];
                nxt_lo_s = {acc_lo_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Add-then-shift-right keeps the carry of the add in the product.
            nxt_hi_s = sum_s[WIDTH:1];
            nxt_lo_s = {sum_s[0], acc_lo_r[WIDTH-1:1]};
        end
        if (op_r) begin
            nxt_zero_s = (nxt_lo_s == {WIDTH{1'b0}});
        end else begin
            nxt_zero_s = (nxt_hi_s == {WIDTH{1'b0}}) && (nxt_lo_s == {WIDTH{1'b0}});
        end
    end

    // Next-state logic of the IDLE/CALC/FIN controller.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    next_state_s = S_CALC;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (last_iter_s) begin
                    next_state_s = S_FIN;
                end else begin
                    next_state_s = S_CALC;
                end
            end
            S_FIN: begin
                next_state_s = S_IDLE;
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // State register, status outputs and the iteration datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            op_r        <= 1'b0;
            div0_pend_r <= 1'b0;
            acc_hi_r    <= {WIDTH{1'b0}};
            acc_lo_r    <= {WIDTH{1'b0}};
            opnd_r      <= {WIDTH{1'b0}};
            result_hi_r <= {WIDTH{1'b0}};
            result_lo_r <= {WIDTH{1'b0}};
            div0_r      <= 1'b0;
            zero_r      <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy_r  <= (next_state_s == S_CALC);
            done_r  <= (next_state_s == S_FIN);
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        op_r        <= bus.op;
                        div0_pend_r <= req_div0_s;
                        cnt_r       <= {CW{1'b0}};
                        acc_hi_r    <= {WIDTH{1'b0}};
                        acc_lo_r    <= bus.op ? bus.a : bus.b;
                        opnd_r      <= bus.op ? bus.b : bus.a;
                    end
                end
                S_CALC: begin
                    if (div0_pend_r) begin
                        // acc_lo_r still holds the untouched dividend.
                        result_hi_r <= acc_lo_r;
                        result_lo_r <= {WIDTH{1'b1}};
                        div0_r      <= 1'b1;
                        zero_r      <= 1'b0;
                    end else begin
                        acc_hi_r <= nxt_hi_s;
                        acc_lo_r <= nxt_lo_s;
                        cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        if (last_iter_s) begin
                            result_hi_r <= nxt_hi_s;
                            result_lo_r <= nxt_lo_s;
                            div0_r      <= 1'b0;
                            zero_r      <= nxt_zero_s;
                        end
                    end
                end
                default: begin
                    div0_pend_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.result_hi = result_hi_r;
    assign bus.result_lo = result_lo_r;
    assign bus.div0      = div0_r;
    assign bus.zero      = zero_r;

endmodule

// File: tb/tb_alu_muldiv.sv
// -----------------------------------------------------------------------------
// tb_alu_muldiv
// Directed, table-driven bench for alu_muldiv (WIDTH = 8) plus hand-written
// sequences for restart-while-busy, reset abort and back-to-back operation.
// -----------------------------------------------------------------------------
module tb_alu_muldiv;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    alu_muldiv_if #(.WIDTH(W)) bus ();

    alu_muldiv #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] hi;
        logic [7:0] lo;
        logic       d0;
        logic       z;
        int         lat;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Run one operation from IDLE and check latency, results and hold.
    task automatic do_op(input logic op_i, input logic [7:0] a_i, input logic [7:0] b_i,
                         input logic [7:0] hi_e, input logic [7:0] lo_e,
                         input logic d0_e, input logic z_e, input int lat_e, input string tag);
        int n;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op_i;
        bus.a     = a_i;
        bus.b     = b_i;
        @(posedge clk);
        #1;
        check({tag, ":busy_k"}, {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        bus.op    = ~op_i;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) seen = 1'b1;
        end
        check({tag, ":latency"}, seen ? 32'(n) : 32'hFFFF_FFFF, 32'(lat_e));
        check({tag, ":hi"}, {24'd0, bus.result_hi}, {24'd0, hi_e});
        check({tag, ":lo"}, {24'd0, bus.result_lo}, {24'd0, lo_e});
        check({tag, ":div0"}, {31'd0, bus.div0}, {31'd0, d0_e});
        check({tag, ":zero"}, {31'd0, bus.zero}, {31'd0, z_e});
        check({tag, ":busy_fin"}, {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1;
        check({tag, ":done_drop"}, {31'd0, bus.done}, 32'd0);
        check({tag, ":hold"}, {16'd0, bus.result_hi, bus.result_lo}, {16'd0, hi_e, lo_e});
    endtask

    initial begin
        int n;
        int ndone;
        int t_done [3];
        bit seen;

        n_vec = 0;
        n_bad = 0;

        //             op    a      b      hi     lo     d0    z     lat
        tbl[0]  = '{1'b0, 8'hFD, 8'h35, 8'h34, 8'h61, 1'b0, 1'b0, 8};
        tbl[1]  = '{1'b1, 8'hFD, 8'h35, 8'h29, 8'h04, 1'b0, 1'b0, 8};
        tbl[2]  = '{1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0, 1'b0, 8};
        tbl[3]  = '{1'b1, 8'h35, 8'h00, 8'h35, 8'hFF, 1'b1, 1'b0, 1};
        tbl[4]  = '{1'b0, 8'h00, 8'h35, 8'h00, 8'h00, 1'b0, 1'b1, 8};
        tbl[5]  = '{1'b1, 8'h10, 8'h03, 8'h01, 8'h05, 1'b0, 1'b0, 8};
        tbl[6]  = '{1'b1, 8'h03, 8'h10, 8'h03, 8'h00, 1'b0, 1'b1, 8};
        tbl[7]  = '{1'b0, 8'h80, 8'h02, 8'h01, 8'h00, 1'b0, 1'b0, 8};
        tbl[8]  = '{1'b1, 8'hFF, 8'h01, 8'h00, 8'hFF, 1'b0, 1'b0, 8};
        tbl[9]  = '{1'b1, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1};
        tbl[10] = '{1'b0, 8'h02, 8'h03, 8'h00, 8'h06, 1'b0, 1'b0, 8};
        tbl[11] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0, 1'b0, 8};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset:busy", {31'd0, bus.busy}, 32'd0);
        check("reset:done", {31'd0, bus.done}, 32'd0);
        check("reset:res", {16'd0, bus.result_hi, bus.result_lo}, 32'd0);
        check("reset:flags", {30'd0, bus.div0, bus.zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo,
                  tbl[i].d0, tbl[i].z, tbl[i].lat, $sformatf("vec%0d", i));
        end

        // START pulse with new operands in the middle of a multiply.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 8'hFD; bus.b = 8'h35;
        @(posedge clk);                 // edge k
        #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01;
        @(posedge clk);                 // edge k+3
        #1;
        bus.start = 1'b0;
        n = 3;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done) seen = 1'b1;
        end
        check("restart:latency", seen ? 32'(n) : 32'hFFFF_FFFF, 32'd8);
        check("restart:result", {16'd0, bus.result_hi, bus.result_lo}, 32'h0000_3461);
        ndone = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("restart:extra_done", 32'(ndone), 32'd0);

        // Reset in the middle of a divide.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b1; bus.a = 8'hFD; bus.b = 8'h35;
        @(posedge clk);                 // edge k
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);                 // edge k+4
        #1;
        rst = 1'b0;
        check("abort:busy", {31'd0, bus.busy}, 32'd0);
        check("abort:done", {31'd0, bus.done}, 32'd0);
        check("abort:res", {16'd0, bus.result_hi, bus.result_lo}, 32'd0);
        check("abort:flags", {30'd0, bus.div0, bus.zero}, 32'd0);
        ndone = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
        end
        check("abort:no_done", 32'(ndone), 32'd0);
        do_op(1'b1, 8'h10, 8'h03, 8'h01, 8'h05, 1'b0, 1'b0, 8, "after_rst");

        // START held high: one operation every WIDTH+2 cycles.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 1'b0; bus.a = 8'h02; bus.b = 8'h03;
        ndone = 0;
        for (int c = 1; c <= 40 && ndone < 3; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                t_done[ndone] = c;
                check($sformatf("stream:res%0d", ndone),
                      {16'd0, bus.result_hi, bus.result_lo}, 32'h0000_0006);
                ndone++;
            end
        end
        check("stream:count", 32'(ndone), 32'd3);
        if (ndone == 3) begin
            check("stream:first", 32'(t_done[0]), 32'd9);
            check("stream:gap1", 32'(t_done[1] - t_done[0]), 32'd10);
            check("stream:gap2", 32'(t_done[2] - t_done[1]), 32'd10);
        end
        bus.start = 1'b0;
        repeat (12) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (register-file data width); results are 2*WIDTH bits split into HI/LO.
REQ-002 CLK  in  1  system clock, all state updates on rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 START  in  1  request to begin an operation, sampled only in IDLE.
REQ-005 OP  in  1  0 = unsigned multiply, 1 = unsigned divide.
REQ-006 A  in  WIDTH  operand X, driven from register-file DX_OUT (dividend / multiplicand).
REQ-007 B  in  WIDTH  operand Y, driven from register-file DY_OUT (divisor / multiplier).
REQ-008 BUSY  out  1  high while an operation is in progress.
REQ-009 DONE  out  1  one-cycle pulse, results valid.
REQ-010 RESULT_HI  out  WIDTH  product upper half / remainder.
REQ-011 RESULT_LO  out  WIDTH  product lower half / quotient.
REQ-012 DIV0  out  1  divide-by-zero indication for the last operation.
REQ-013 ZERO  out  1  last result zero: full 2*WIDTH product == 0 (mul), quotient == 0 (div).

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, CALC, FIN.
REQ-015 IDLE: on edge k with START=1, the block SHALL latch A, B, OP, clear the iteration counter, assert BUSY and go to CALC; START=0 keeps IDLE.
REQ-016 Exception: OP=1 with B=0 at edge k SHALL go directly to FIN with DIV0=1, RESULT_LO=all ones, RESULT_HI=A, ZERO=0.
REQ-017 CALC SHALL perform exactly one iteration per clock, WIDTH iterations total, then enter FIN at edge k+WIDTH.
REQ-018 Multiply SHALL be unsigned shift-add (LSB-first on latched B), producing the exact 2*WIDTH-bit product, no truncation.
REQ-019 Divide SHALL be unsigned restoring division (MSB-first on latched A), producing quotient < 2^WIDTH and remainder < B.
REQ-020 FIN SHALL last one cycle: DONE=1, BUSY=0, results/DIV0/ZERO valid; next edge returns to IDLE with DONE=0.
REQ-021 RESULT_HI, RESULT_LO, DIV0, ZERO SHALL update only when entering FIN and hold until the next FIN or reset.
REQ-022 Intermediate partial results SHALL NOT appear on RESULT_HI/RESULT_LO during CALC.
REQ-023 START while in CALC or FIN SHALL be ignored (no restart, no queueing); START=1 held through FIN starts a new operation on the first IDLE edge.
REQ-024 Changes on A, B, OP after edge k SHALL NOT affect the running operation.
REQ-025 Latency: DONE high in the cycle after edge k+WIDTH (normal) or edge k+1 (divide-by-zero); throughput one operation per WIDTH+2 cycles.

Reset
REQ-026 RST=1 at any edge SHALL force IDLE, BUSY=0, DONE=0, DIV0=0, ZERO=0, RESULT_HI=0, RESULT_LO=0, counter=0.
REQ-027 RST SHALL take priority over START and abort any in-flight operation without producing DONE.
REQ-028 First START accepted on the first edge with RST=0.

Verification
REQ-029 OP=0, A=0xFD, B=0x35, START one cycle -> BUSY 8 cycles, DONE pulse at k+8, RESULT_HI=0x34, RESULT_LO=0x61, ZERO=0, DIV0=0.
REQ-030 OP=1, A=0xFD, B=0x35 -> DONE at k+8, RESULT_LO=0x04, RESULT_HI=0x29; then OP=0, A=0xFF, B=0xFF -> 0xFE / 0x01.
REQ-031 OP=1, A=0x35, B=0x00 -> DONE at k+1, DIV0=1, RESULT_LO=0xFF, RESULT_HI=0x35; following OP=0, A=0, B=0x35 -> DIV0=0, ZERO=1, results 0x00/0x00.
REQ-032 Start mul 0xFD*0x35, pulse START and change A/B to 0x01 at k+3 -> single DONE at k+8 with 0x3461, no second operation.
REQ-033 Start divide, assert RST at k+4 -> all outputs 0, no DONE; new START after reset (0x10/0x03) -> quotient 0x05, remainder 0x01.
REQ-034 START held high continuously, OP=0, A=0x02, B=0x03 -> DONE pulses every 10 cycles, each with result 0x0006.
